// File: rtl/imem_server_if.sv
// Fetch-path bundle between a CPU fetch unit (master) and the instruction
// memory server (slave): a valid/ready request channel carrying a byte
// address and a valid/ready response channel carrying the 32-bit word.
interface imem_server_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data,
    output rsp_err
  );
endinterface

// File: rtl/imem_server.sv
// Byte-addressed, big-endian instruction memory on the responder side of the
// fetch path. One request is served at a time; the word (or an error flag)
// is captured when the request is accepted and presented LATENCY cycles later
// until the consumer takes it. A byte-serial load port fills the memory from
// index 0 upward; memory contents survive reset.
module imem_server #(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
  parameter int unsigned LATENCY     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  imem_server_if.slave                 bus,
  input  logic                         ld_start,
  input  logic                         ld_valid,
  input  logic [7:0]                   ld_byte,
  input  logic                         ld_last,
  output logic                         ld_done,
  output logic [$clog2(DEPTH_BYTES):0] ld_count
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    LOAD = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  lat_cnt;
  logic [7:0]  mem [DEPTH_BYTES];

  logic [31:0] idx_p0;
  logic [AW-1:0] ofs_p0;
  logic        err_p0;
  logic [31:0] word_p0;
  logic        accept_p0;

  logic        rsp_valid_p1;
  logic [31:0] rsp_data_p1;
  logic        rsp_err_p1;

  logic        ld_wr;
  logic        ld_end;

  // Stage p0: decode the request address and read the four bytes at idx.
  // The subtraction wraps, so addresses below the base look huge and fail
  // the range test. The read index is only meaningful when err_p0 is low.
  always_comb begin
    idx_p0  = bus.req_addr - BASE_ADDR;
    ofs_p0  = idx_p0[AW-1:0];
    err_p0  = (idx_p0[1:0] != 2'b00) || (idx_p0 > 32'(DEPTH_BYTES - 4));
    word_p0 = {mem[ofs_p0],
               mem[ofs_p0 + AW'(1)],
               mem[ofs_p0 + AW'(2)],
               mem[ofs_p0 + AW'(3)]};
  end

  // A pending ld_start steals the IDLE cycle from any simultaneous request.
  assign bus.req_ready = (state == IDLE) && !ld_start;
  assign accept_p0     = bus.req_valid && bus.req_ready;

  // The load pointer is the byte count itself; the last index ends the load
  // even without ld_last so the pointer can never wrap onto index 0.
  assign ld_wr  = (state == LOAD) && ld_valid;
  assign ld_end = ld_wr && (ld_last || (ld_count[AW-1:0] == AW'(DEPTH_BYTES - 1)));

  // Stage p1: registered response towards the consumer.
  assign bus.rsp_valid = rsp_valid_p1;
  assign bus.rsp_data  = rsp_data_p1;
  assign bus.rsp_err   = rsp_err_p1;

  // Byte storage: written only by the load port, never cleared by reset.
  always_ff @(posedge clk) begin
    if (ld_wr) begin
      mem[ld_count[AW-1:0]] <= ld_byte;
    end
  end

  // Control FSM: request capture, latency countdown, response hold, load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lat_cnt      <= 4'd0;
      rsp_valid_p1 <= 1'b0;
      rsp_data_p1  <= 32'd0;
      rsp_err_p1   <= 1'b0;
      ld_done      <= 1'b0;
      ld_count     <= '0;
    end else begin
      ld_done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_start) begin
            state    <= LOAD;
            ld_count <= '0;
          end else if (accept_p0) begin
            rsp_data_p1 <= err_p0 ? 32'd0 : word_p0;
            rsp_err_p1  <= err_p0;
            if (LATENCY == 1) begin
              state        <= RESP;
              rsp_valid_p1 <= 1'b1;
            end else begin
              state   <= WAIT;
              lat_cnt <= 4'(LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (lat_cnt == 4'd1) begin
            state        <= RESP;
            rsp_valid_p1 <= 1'b1;
            lat_cnt      <= 4'd0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            state        <= IDLE;
            rsp_valid_p1 <= 1'b0;
          end
        end
        LOAD: begin
          if (ld_wr) begin
            ld_count <= ld_count + CW'(1);
            if (ld_end) begin
              state   <= IDLE;
              ld_done <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
